// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the execute-stage branch resolver:
// condition codes, default PC width and FSM state encoding.
package branch_resolve_unit_pkg;

  localparam int PC_W = 32;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EVAL  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // AL/NV never look at the flags, so they need
  // not wait for in-flight flag writers.
  function automatic logic is_uncond(
    input logic [3:0] c
  );
    return (c == COND_AL) || (c == COND_NV);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// condition_checker: combinational NZCV condition evaluation.
// Ports: cond, four flags in; condition_met out. NV never passes.
module condition_checker
  import branch_resolve_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       negative_flag,
  input  logic       overflow_flag,
  output logic       condition_met
);

  logic nv_eq;

  assign nv_eq = (negative_flag == overflow_flag);

  always_comb begin
    condition_met = 1'b0;
    unique case (cond)
      COND_EQ: condition_met = zero_flag;
      COND_NE: condition_met = !zero_flag;
      COND_CS: condition_met = carry_flag;
      COND_CC: condition_met = !carry_flag;
      COND_MI: condition_met = negative_flag;
      COND_PL: condition_met = !negative_flag;
      COND_VS: condition_met = overflow_flag;
      COND_VC: condition_met = !overflow_flag;
      COND_HI: condition_met = carry_flag && !zero_flag;
      COND_LS: condition_met = !carry_flag || zero_flag;
      COND_GE: condition_met = nv_eq;
      COND_LT: condition_met = !nv_eq;
      COND_GT: condition_met = !zero_flag && nv_eq;
      COND_LE: condition_met = zero_flag || !nv_eq;
      COND_AL: condition_met = 1'b1;
      COND_NV: condition_met = 1'b0;
      default: condition_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage conditional branch resolver: captures one branch,
// waits for final NZCV, then redirects+flushes or retires not-taken.
// Ports: br_* handshake/payload in, flags + flags_pending in,
// redirect/link/flush/stall/br_done out, saturating stats counters.
module branch_resolve_unit #(
  parameter int PC_W         = branch_resolve_unit_pkg::PC_W,
  parameter int OFF_W        = 24,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic             br_link,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_offset,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             negative_flag,
  input  logic             overflow_flag,
  input  logic             flags_pending,
  output logic             stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
  output logic             flush,
  output logic             br_done,
  output logic             br_taken,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  import branch_resolve_unit_pkg::*;

  localparam logic [PC_W-1:0] PC_4 = PC_W'(4);
  localparam logic [PC_W-1:0] PC_8 = PC_W'(8);
  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [3:0]       cond_q;
  logic             link_q;
  logic [PC_W-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;
  logic             eval_ok;
  logic             met_q;
  logic [3:0]       fcnt;

  logic             cond_met;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  ret_addr;

  condition_checker u_cond (
    .cond          (cond_q),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag),
    .condition_met (cond_met)
  );

  assign off_ext = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign target = pc_q + PC_8 + (off_ext << 2);
  assign ret_addr = pc_q + PC_4;

  // EVAL is split in two: first sample the flags once they are
  // final (eval_ok), then publish the result on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cond_q         <= '0;
      link_q         <= 1'b0;
      pc_q           <= '0;
      off_q          <= '0;
      eval_ok        <= 1'b0;
      met_q          <= 1'b0;
      fcnt           <= '0;
      br_ready       <= 1'b1;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_data      <= '0;
      flush          <= 1'b0;
      br_done        <= 1'b0;
      br_taken       <= 1'b0;
      total_cnt      <= '0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      br_done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (br_valid && br_ready) begin
            cond_q   <= br_cond;
            link_q   <= br_link;
            pc_q     <= br_pc;
            off_q    <= br_offset;
            eval_ok  <= 1'b0;
            br_ready <= 1'b0;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (!eval_ok) begin
            if (flags_pending && !is_uncond(cond_q)) begin
              stall <= 1'b1;
            end else begin
              stall   <= 1'b0;
              met_q   <= cond_met;
              eval_ok <= 1'b1;
            end
          end else begin
            br_done  <= 1'b1;
            br_taken <= met_q;
            if (total_cnt != CNT_MAX)
              total_cnt <= total_cnt + 1'b1;
            if (met_q) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
              if (link_q) begin
                link_we   <= 1'b1;
                link_data <= ret_addr;
              end
              if (taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + 1'b1;
              flush <= 1'b1;
              stall <= 1'b1;
              fcnt  <= FL_INIT;
              state <= ST_FLUSH;
            end else begin
              br_ready <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (fcnt <= 4'd1) begin
            flush    <= 1'b0;
            stall    <= 1'b0;
            br_ready <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          flush    <= 1'b0;
          stall    <= 1'b0;
          br_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Counters are built 4 bits wide so saturation is reachable.
module tb_branch_resolve_unit;

  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic          br_ready;
  logic [3:0]    br_cond;
  logic          br_link;
  logic [31:0]   br_pc;
  logic [23:0]   br_offset;
  logic          zero_flag;
  logic          carry_flag;
  logic          negative_flag;
  logic          overflow_flag;
  logic          flags_pending;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          link_we;
  logic [31:0]   link_data;
  logic          flush;
  logic          br_done;
  logic          br_taken;
  logic [CW-1:0] total_cnt;
  logic [CW-1:0] taken_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_total = 0;
  int exp_taken = 0;
  int lat;
  int stl;
  int nfl;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W         (32),
    .OFF_W        (24),
    .FLUSH_CYCLES (2),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_link        (br_link),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .negative_flag  (negative_flag),
    .overflow_flag  (overflow_flag),
    .flags_pending  (flags_pending),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_data      (link_data),
    .flush          (flush),
    .br_done        (br_done),
    .br_taken       (br_taken),
    .total_cnt      (total_cnt),
    .taken_cnt      (taken_cnt)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Issue one branch and wait (bounded) for br_done.
  // rel>0 releases flags_pending with N=V=Z=0 at that cycle.
  task automatic run_br(
    input  logic [3:0]  c,
    input  logic        l,
    input  logic [31:0] pc,
    input  logic [23:0] off,
    input  int          rel,
    output int          lt,
    output int          st
  );
    int w;
    w = 0;
    while (!br_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_issue", br_ready, 1);
    br_cond   = c;
    br_link   = l;
    br_pc     = pc;
    br_offset = off;
    br_valid  = 1'b1;
    @(posedge clk);
    #1 br_valid = 1'b0;
    lt = 0;
    st = 0;
    do begin
      @(negedge clk);
      lt++;
      if (stall && !br_done) st++;
      if (rel != 0 && lt == rel) begin
        flags_pending = 1'b0;
        zero_flag     = 1'b0;
        negative_flag = 1'b0;
        overflow_flag = 1'b0;
      end
    end while (!br_done && lt < 40);
    check("br_done_seen", br_done, 1);
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (flush && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    br_valid = 1'b0;
    br_cond = 4'h0;
    br_link = 1'b0;
    br_pc = '0;
    br_offset = '0;
    zero_flag = 1'b0;
    carry_flag = 1'b0;
    negative_flag = 1'b0;
    overflow_flag = 1'b0;
    flags_pending = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", br_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_stall", stall, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_done", br_done, 0);
    check("rst_total", total_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // EQ taken, Z=1
    zero_flag = 1'b1;
    run_br(4'h0, 1'b0, 32'h100, 24'h000010, 0, lat, stl);
    exp_total = sat(exp_total);
    exp_taken = sat(exp_taken);
    check("eq_latency", lat, 3);
    check("eq_stall", stl, 0);
    check("eq_redir_v", redirect_valid, 1);
    check("eq_redir_pc", redirect_pc, 32'h148);
    check("eq_taken", br_taken, 1);
    check("eq_link_we", link_we, 0);
    check("eq_total", total_cnt, exp_total);
    check("eq_taken_cnt", taken_cnt, exp_taken);
    count_flush(nfl);
    check("eq_flush_len", nfl, 2);
    check("eq_redir_pulse", redirect_valid, 0);
    check("eq_ready_after", br_ready, 1);

    // BL always, pending ignored
    flags_pending = 1'b1;
    run_br(4'hE, 1'b1, 32'h200, 24'hFFFFFE, 0, lat, stl);
    exp_total = sat(exp_total);
    exp_taken = sat(exp_taken);
    check("bl_latency", lat, 3);
    check("bl_redir_pc", redirect_pc, 32'h200);
    check("bl_link_we", link_we, 1);
    check("bl_link_data", link_data, 32'h204);
    count_flush(nfl);
    check("bl_flush_len", nfl, 2);
    check("bl_link_pulse", link_we, 0);
    flags_pending = 1'b0;

    // NE with Z=1: not taken
    zero_flag = 1'b1;
    run_br(4'h1, 1'b0, 32'h300, 24'h000004, 0, lat, stl);
    exp_total = sat(exp_total);
    check("ne_taken", br_taken, 0);
    check("ne_redir_v", redirect_valid, 0);
    check("ne_flush", flush, 0);
    check("ne_total", total_cnt, exp_total);
    check("ne_taken_cnt", taken_cnt, exp_taken);
    check("ne_redir_hold", redirect_pc, 32'h200);
    check("ne_ready", br_ready, 1);

    // GT waits on pending; stale Z=1 would fail GT
    zero_flag = 1'b1;
    flags_pending = 1'b1;
    run_br(4'hC, 1'b0, 32'h1000, 24'hFFFFFF, 4, lat, stl);
    exp_total = sat(exp_total);
    exp_taken = sat(exp_taken);
    check("gt_stall_cycles", stl, 3);
    check("gt_latency", lat, 6);
    check("gt_taken", br_taken, 1);
    check("gt_redir_pc", redirect_pc, 32'h1004);
    count_flush(nfl);
    check("gt_flush_len", nfl, 2);

    // address wrap
    run_br(4'hE, 1'b0, 32'hFFFFFFF8, 24'h0, 0, lat, stl);
    exp_total = sat(exp_total);
    exp_taken = sat(exp_taken);
    check("wrap_redir_pc", redirect_pc, 32'h0);
    check("wrap_total", total_cnt, exp_total);

    // reset in the middle of FLUSH
    check("rst_mid_flush_pre", flush, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_flush", flush, 0);
    check("rst_mid_ready", br_ready, 1);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_taken_cnt", taken_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_total = 0;
    exp_taken = 0;
    @(negedge clk);

    // saturation of the taken/total counters
    for (int i = 0; i < CMAX + 1; i++) begin
      run_br(4'hE, 1'b0, 32'h40, 24'h1, 0, lat, stl);
      exp_total = sat(exp_total);
      exp_taken = sat(exp_taken);
      if (i == CMAX - 1)
        check("sat_reach", taken_cnt, exp_taken);
      count_flush(nfl);
    end
    check("sat_hold_taken", taken_cnt, 4'hF);
    check("sat_hold_total", total_cnt, exp_total);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolver sitting directly downstream of condition_checker.
- Accepts one conditional branch at a time from decode and holds it until the NZCV flags it depends on are final.
- Evaluates the condition, then either redirects fetch (with optional link write and pipeline flush) or retires the branch as not-taken.
- Keeps saturating branch statistics counters for performance debug.

Parameters:
- PC_W, 32, program counter / target width
- OFF_W, 24, signed word-offset field width
- FLUSH_CYCLES, 2, cycles flush held high after a taken branch (legal range 1..15)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  decode presents a branch
- br_ready  out  1  unit can accept a branch (high only in IDLE)
- br_cond  in  4  condition code, same encoding as condition_checker (1110 AL, 1111 NV)
- br_link  in  1  branch-with-link
- br_pc  in  PC_W  address of the branch instruction
- br_offset  in  OFF_W  signed word offset
- zero_flag, carry_flag, negative_flag, overflow_flag  in  1 each  architectural flags
- flags_pending  in  1  a flag-setting instruction ahead has not yet written flags
- stall  out  1  hold upstream stages
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  PC_W  branch target
- link_we  out  1  one-cycle link-register write strobe
- link_data  out  PC_W  return address
- flush  out  1  squash younger instructions in fetch/decode
- br_done  out  1  one-cycle pulse on every resolution, taken or not
- br_taken  out  1  qualifies br_done
- total_cnt  out  CNT_W  resolved branches, saturating
- taken_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Reset: state IDLE. All outputs 0 except br_ready=1. Counters 0.
- Reset mid-operation discards the captured branch and any pending redirect/flush immediately.
- States: IDLE, EVAL, FLUSH. All outputs are registered.
- IDLE: when br_valid and br_ready are both high at an edge, capture cond, link, pc and offset, then go to EVAL. br_ready=0 outside IDLE.
- EVAL, waiting: if flags_pending=1 and cond is not AL/NV, stall=1 and remain in EVAL.
- EVAL, AL/NV: bypass flags_pending and resolve in the first EVAL cycle.
- EVAL, resolving: evaluate condition_met on the current flags.
  - Taken: at the next edge, redirect_valid=1, redirect_pc = pc + 8 + (sign_extend(offset) << 2), truncated modulo 2^PC_W (wrap permitted).
  - Taken with link: link_we=1, link_data = pc + 4 (mod 2^PC_W).
  - Taken: br_done=1, br_taken=1, flush=1, load counter with FLUSH_CYCLES, go to FLUSH.
  - Not taken: br_done=1, br_taken=0, no redirect, no flush, go to IDLE.
- Fixed latency with no pending flags: accept at edge T, redirect/br_done visible in the cycle after edge T+2.
- FLUSH: flush=1 and stall=1. The counter decrements each cycle. When the counter reaches 1, the next edge returns to IDLE. flush is high for exactly FLUSH_CYCLES consecutive cycles.
- redirect_valid, link_we and br_done are single-cycle pulses. redirect_pc and link_data hold their values until the next taken branch.
- Counters: total_cnt increments on every br_done and taken_cnt on every taken br_done. Both saturate at all-ones and do not wrap.
- br_valid during a non-IDLE state is ignored. Decode must hold it, so no request is lost.

Decomposition:
- Shared package: condition code constants (COND_EQ..COND_NV), PC_W, and the state encoding (IDLE/EVAL/FLUSH).
- Instantiate the existing condition_checker as the single sub-module. Target computation and counters stay inline.

Test Plan:
- Taken EQ, Z=1, pending=0, pc=0x100, offset=0x000010 → redirect_pc=0x148, flush high 2 cycles, taken_cnt=1, latency as specified.
- BL, AL, pc=0x200, offset=0xFFFFFE, flags_pending=1 → no wait; redirect_pc=0x200, link_we=1, link_data=0x204.
- NE with Z=1 → br_done=1, br_taken=0, no redirect/flush, total_cnt=1, taken_cnt=0.
- GT with flags_pending=1 for 3 cycles, then flags N=0 V=0 Z=0 → stall high 3 cycles, then taken. The flags before the release are ignored.
- Wrap: pc=0xFFFFFFF8, offset=0, AL → redirect_pc=0x00000000. Separately, assert rst during FLUSH → flush=0, br_ready=1 at once.
- Preload stimulus so 0xFFFF branches are taken, then take one more → taken_cnt stays 0xFFFF.
